// File: rtl/ff_pack_reader_if.sv
// FIFO read side and packet handshake of ff_pack_reader, grouped as one bus.
interface ff_pack_reader_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_WORDS     = 4,
  parameter int PKT_CNT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]           ff_data_i;
  logic                            ff_empty_i;
  logic                            ff_rd_valid_o;
  logic [NUM_WORDS*DATA_WIDTH-1:0] pkt_data_o;
  logic                            pkt_valid_o;
  logic                            pkt_ready_i;
  logic [PKT_CNT_WIDTH-1:0]        pkt_cnt_o;

  modport master (
    input  ff_data_i, ff_empty_i, pkt_ready_i,
    output ff_rd_valid_o, pkt_data_o, pkt_valid_o, pkt_cnt_o
  );

  modport slave (
    output ff_data_i, ff_empty_i, pkt_ready_i,
    input  ff_rd_valid_o, pkt_data_o, pkt_valid_o, pkt_cnt_o
  );
endinterface

// File: rtl/ff_pack_reader.sv
// Pops words from the ff FIFO and packs NUM_WORDS of them into one packet
// presented over valid/ready.
//   state | meaning
//   FILL  | issuing FIFO reads and capturing returned words
//   HOLD  | packet presented, waiting for pkt_ready_i
module ff_pack_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_WORDS     = 4,
  parameter int CNT_WIDTH     = $clog2(NUM_WORDS+1),
  parameter int PKT_CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  ff_pack_reader_if.master bus
);
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_RD    = CNT_WIDTH'(NUM_WORDS);
  localparam logic [CNT_WIDTH-1:0] LAST_WORD = CNT_WIDTH'(NUM_WORDS-1);

  state_t                          state_q, state_d;
  logic [CNT_WIDTH-1:0]            rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]            cap_cnt_q, cap_cnt_d;
  logic                            rd_pend_q;
  logic [NUM_WORDS*DATA_WIDTH-1:0] pkt_data_q, pkt_data_d;
  logic                            pkt_valid_q, pkt_valid_d;
  logic [PKT_CNT_WIDTH-1:0]        pkt_cnt_q, pkt_cnt_d;
  logic                            rd_en;
  logic                            xfer;

  // Gated by rst so no pop escapes while the block is held in reset.
  assign rd_en = !rst && (state_q == FILL) && !bus.ff_empty_i && (rd_cnt_q < MAX_RD);
  assign xfer  = pkt_valid_q && bus.pkt_ready_i;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = pkt_valid_q;
    pkt_cnt_d   = pkt_cnt_q;
    unique case (state_q)
      FILL: begin
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
        end
        if (rd_pend_q) begin
          for (int i = 0; i < NUM_WORDS; i++) begin
            if (cap_cnt_q == CNT_WIDTH'(i)) begin
              pkt_data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.ff_data_i;
            end
          end
          cap_cnt_d = cap_cnt_q + CNT_WIDTH'(1);
          if (cap_cnt_q == LAST_WORD) begin
            state_d     = HOLD;
            pkt_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (xfer) begin
          state_d     = FILL;
          pkt_valid_d = 1'b0;
          rd_cnt_d    = '0;
          cap_cnt_d   = '0;
          pkt_cnt_d   = pkt_cnt_q + PKT_CNT_WIDTH'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      rd_cnt_q    <= '0;
      cap_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      rd_pend_q   <= rd_en;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign bus.ff_rd_valid_o = rd_en;
  assign bus.pkt_data_o    = pkt_data_q;
  assign bus.pkt_valid_o   = pkt_valid_q;
  assign bus.pkt_cnt_o     = pkt_cnt_q;
endmodule

// File: tb/tb_ff_pack_reader.sv
// Bench for ff_pack_reader: FIFO model plus packet scoreboard, directed
// scenarios followed by randomized traffic.
module tb_ff_pack_reader;
  localparam int DW  = 8;
  localparam int NW  = 4;
  localparam int PW  = 16;
  localparam int PKW = NW*DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ff_pack_reader_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .PKT_CNT_WIDTH(PW)) bus ();
  ff_pack_reader #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .PKT_CNT_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]  fifo [$];
  logic [DW-1:0]  part [$];
  logic [PKW-1:0] exp_pkts [$];
  logic [PKW-1:0] got_pkts [$];

  logic           wr_en     = 1'b0;
  logic [DW-1:0]  wr_data   = '0;
  logic           ready_r   = 1'b0;
  logic [DW-1:0]  fdata_r   = '0;
  logic           empty_r   = 1'b1;
  logic [PW-1:0]  model_cnt = '0;
  int             rd_total  = 0;
  int             rd_in_pkt = 0;
  logic           prev_hold = 1'b0;
  logic [PKW-1:0] held_data = '0;

  assign bus.ff_data_i   = fdata_r;
  assign bus.ff_empty_i  = empty_r;
  assign bus.pkt_ready_i = ready_r;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO with one-cycle read latency, and the packet reference model:
  // every popped word is appended in order; each NW of them form one packet.
  always @(posedge clk) begin : model
    logic [DW-1:0]  v;
    logic [PKW-1:0] pk;
    if (rst) begin
      part.delete();
      exp_pkts.delete();
      rd_in_pkt = 0;
      model_cnt = '0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", bus.pkt_valid_o, 1);
        chk("hold_data", bus.pkt_data_o, held_data);
      end
      prev_hold = bus.pkt_valid_o && !bus.pkt_ready_i;
      held_data = bus.pkt_data_o;
      if (bus.pkt_valid_o && bus.pkt_ready_i) begin
        chk("pkt_expected", exp_pkts.size() > 0, 1);
        if (exp_pkts.size() > 0) chk("pkt_data", bus.pkt_data_o, exp_pkts.pop_front());
        chk("pkt_cnt", bus.pkt_cnt_o, model_cnt);
        model_cnt = model_cnt + 1'b1;
        got_pkts.push_back(bus.pkt_data_o);
        rd_in_pkt = 0;
      end
      if (bus.ff_rd_valid_o) begin
        chk("rd_while_empty", fifo.size() > 0, 1);
        rd_total++;
        rd_in_pkt++;
        chk("rd_per_pkt", rd_in_pkt <= NW, 1);
        if (fifo.size() > 0) begin
          v = fifo.pop_front();
          fdata_r <= v;
          part.push_back(v);
          if (part.size() == NW) begin
            pk = '0;
            for (int i = 0; i < NW; i++) pk = pk | (PKW'(part[i]) << (i*DW));
            exp_pkts.push_back(pk);
            part.delete();
          end
        end
      end
    end
    if (wr_en) fifo.push_back(wr_data);
    empty_r <= (fifo.size() == 0);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_pkts(input int n, input int budget);
    int c = 0;
    while (got_pkts.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("pkt_arrival", got_pkts.size(), n);
  endtask

  task automatic expect_pkt(input string tag, input logic [PKW-1:0] exp);
    if (got_pkts.size() > 0) chk(tag, got_pkts.pop_front(), exp);
    else chk({tag, "_missing"}, got_pkts.size(), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    got_pkts.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0]    rd_vec;
    logic [11:0]    vld_vec;
    logic [PKW-1:0] dcap;
    int             rdc;
    int             rd0;
    int             c;

    // reset state
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd", bus.ff_rd_valid_o, 0);
    chk("rst_valid", bus.pkt_valid_o, 0);
    chk("rst_data", bus.pkt_data_o, 0);
    chk("rst_cnt", bus.pkt_cnt_o, 0);

    // back-to-back words: read pattern and packet latency
    ready_r = 1'b1;
    rd_vec  = '0;
    vld_vec = '0;
    dcap    = '0;
    for (int k = 0; k < 12; k++) begin
      wr_en   = (k < 4);
      wr_data = DW'(k + 1);
      @(negedge clk);
      rd_vec[k]  = bus.ff_rd_valid_o;
      vld_vec[k] = bus.pkt_valid_o;
      if (bus.pkt_valid_o) dcap = bus.pkt_data_o;
    end
    wr_en = 1'b0;
    chk("t2_rd_pattern", rd_vec, 12'h00F);
    chk("t2_valid_pattern", vld_vec, 12'h020);
    chk("t2_valid_data", dcap, 32'h04030201);
    chk("t2_cnt", bus.pkt_cnt_o, 1);
    expect_pkt("t2_pkt", 32'h04030201);

    // sparse arrivals: one read per word, never while empty
    rdc = 0;
    for (int w = 0; w < 4; w++) begin
      wr_en   = 1'b1;
      wr_data = DW'(8'h10 + w);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        wr_en = 1'b0;
        rdc += int'(bus.ff_rd_valid_o);
      end
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rdc += int'(bus.ff_rd_valid_o);
    end
    chk("t3_reads", rdc, 4);
    wait_pkts(1, 20);
    expect_pkt("t3_pkt", 32'h13121110);

    // backpressure: packet held, no reads, then resume
    ready_r = 1'b0;
    for (int w = 0; w < 4; w++) push(DW'(8'h21 + w));
    c = 0;
    while (!bus.pkt_valid_o && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("t4_valid", bus.pkt_valid_o, 1);
    rdc = 0;
    for (int w = 0; w < 4; w++) begin
      push(DW'(8'h31 + w));
      rdc += int'(bus.ff_rd_valid_o);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rdc += int'(bus.ff_rd_valid_o);
    end
    chk("t4_reads_in_hold", rdc, 0);
    chk("t4_valid_held", bus.pkt_valid_o, 1);
    chk("t4_data_held", bus.pkt_data_o, 32'h24232221);
    ready_r = 1'b1;
    @(negedge clk);
    chk("t4_rd_resume", bus.ff_rd_valid_o, 1);
    wait_pkts(2, 30);
    expect_pkt("t4_pkt0", 32'h24232221);
    expect_pkt("t4_pkt1", 32'h34333231);
    chk("t4_cnt", bus.pkt_cnt_o, 4);

    // reset with a partial packet captured
    push(8'hA0);
    push(8'hA1);
    idle(4);
    chk("t5_partial", bus.pkt_data_o, 32'h3433A1A0);
    rst = 1'b1;
    #1;
    chk("t5_rst_data", bus.pkt_data_o, 0);
    chk("t5_rst_cnt", bus.pkt_cnt_o, 0);
    chk("t5_rst_valid", bus.pkt_valid_o, 0);
    @(negedge clk);
    rst = 1'b0;
    got_pkts.delete();
    for (int w = 0; w < 4; w++) push(DW'(8'hB0 + w));
    wait_pkts(1, 30);
    expect_pkt("t5_pkt", 32'hB3B2B1B0);
    chk("t5_cnt", bus.pkt_cnt_o, 1);

    // streaming two packets from reset
    do_reset();
    rd0 = rd_total;
    for (int w = 0; w < 8; w++) push(DW'(w + 1));
    wait_pkts(2, 40);
    expect_pkt("t6_pkt0", 32'h04030201);
    expect_pkt("t6_pkt1", 32'h08070605);
    idle(2);
    chk("t6_cnt", bus.pkt_cnt_o, 2);
    chk("t6_reads", rd_total - rd0, 8);

    // randomized traffic with backpressure and one reset, checked by the model
    for (int k = 0; k < 3000; k++) begin
      wr_en   = (fifo.size() < 16) && ($urandom_range(0, 2) != 0);
      wr_data = DW'($urandom);
      ready_r = ($urandom_range(0, 3) != 0);
      if (k == 1500) rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    wr_en   = 1'b0;
    ready_r = 1'b1;
    idle(20);
    chk("rand_cnt", bus.pkt_cnt_o, model_cnt);
    chk("rand_valid_drained", bus.pkt_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
